dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dsd_mem_pkg.sv | 20 ++
 rtl/rr_arb2.sv | 14 +
 rtl/dmem_arbiter.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/dsd_mem_pkg.sv
// Shared widths, FSM state type and address helpers for the data-memory
// arbiter and its sub-blocks.
package dsd_mem_pkg;

  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 32;
  localparam int MEM_AW    = 14;
  localparam int NUM_PORTS = 2;

  typedef enum logic {
    ARB   = 1'b0,
    LOCK1 = 1'b1
  } arb_state_e;

  // Only word accesses are performed; any byte offset is an error.
  function automatic logic misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input priority picker. prio=1 lets port 0 win a tie, prio=0 lets port 1.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       prio,
  output logic [1:0] gnt
);

  always_comb begin
    gnt    = 2'b00;
    gnt[0] = req[0] & (prio | ~req[1]);
    gnt[1] = req[1] & (~prio | ~req[0]);
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: round-robin between processor and DMA/debug,
// with a bounded exclusive lock for port 1 and word-alignment checking.
module dmem_arbiter
  import dsd_mem_pkg::*;
#(
  parameter int LOCK_MAX = 64,
  parameter bit P0_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              resetn,

  input  logic              p0_req,
  input  logic              p0_wr,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_err,

  input  logic              p1_req,
  input  logic              p1_wr,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  input  logic              p1_lock,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_err,

  output logic [MEM_AW-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic              lock_timeout
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  logic [NUM_PORTS-1:0]             req, wr, mis, gnt, rr_gnt;
  logic [NUM_PORTS-1:0][ADDR_W-1:0] addr;
  logic [NUM_PORTS-1:0][DATA_W-1:0] wdata, rdata;

  arb_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 prio_q, prio_d;
  logic                 blk_q, blk_d;
  logic                 tmo_q, tmo_d;
  logic [MEM_AW-1:0]    addr_hold_q, addr_hold_d;
  logic [NUM_PORTS-1:0] rvalid_q, rvalid_d;
  logic [NUM_PORTS-1:0] err_q, err_d;
  logic [NUM_PORTS-1:0] rd_q, rd_d;

  assign req   = {p1_req, p0_req};
  assign wr    = {p1_wr, p0_wr};
  assign addr  = {p1_addr, p0_addr};
  assign wdata = {p1_wdata, p0_wdata};
  assign mis   = {misaligned(p1_addr[1:0]), misaligned(p0_addr[1:0])};

  rr_arb2 u_rr_arb2 (
    .req  (req),
    .prio (prio_q),
    .gnt  (rr_gnt)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ARB;
      cnt_q       <= '0;
      prio_q      <= P0_FIRST;
      blk_q       <= 1'b0;
      tmo_q       <= 1'b0;
      addr_hold_q <= '0;
      rvalid_q    <= '0;
      err_q       <= '0;
      rd_q        <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prio_q      <= prio_d;
      blk_q       <= blk_d;
      tmo_q       <= tmo_d;
      addr_hold_q <= addr_hold_d;
      rvalid_q    <= rvalid_d;
      err_q       <= err_d;
      rd_q        <= rd_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prio_d  = prio_q;
    blk_d   = blk_q;
    tmo_d   = 1'b0;
    if (!p1_lock) blk_d = 1'b0;
    case (state_q)
      ARB: begin
        if (gnt[0]) prio_d = 1'b0;
        if (gnt[1]) begin
          prio_d = 1'b1;
          // After a forced release the lock request is ignored until it drops.
          if (p1_lock && !blk_q) begin
            state_d = LOCK1;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      LOCK1: begin
        if (!p1_lock) begin
          state_d = ARB;
          prio_d  = 1'b1;
          cnt_d   = '0;
        end else if (cnt_q >= CNT_W'(LOCK_MAX)) begin
          state_d = ARB;
          prio_d  = 1'b1;
          cnt_d   = '0;
          blk_d   = 1'b1;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ARB;
    endcase
  end

  // Output logic: grants are combinational and forced low in reset
  always_comb begin
    gnt = '0;
    if (resetn) begin
      if (state_q == LOCK1) gnt = {req[1], 1'b0};
      else                  gnt = rr_gnt;
    end
  end

  // Memory-side mux; the address holds when nobody is granted
  always_comb begin
    mem_addr = addr_hold_q;
    if (gnt[1])      mem_addr = addr[1][ADDR_W-1:2];
    else if (gnt[0]) mem_addr = addr[0][ADDR_W-1:2];
    addr_hold_d = mem_addr;
    mem_wdata   = gnt[1] ? wdata[1] : wdata[0];
    mem_wr      = |(gnt & wr & ~mis);
  end

  always_comb begin
    rvalid_d = gnt;
    err_d    = gnt & mis;
    rd_d     = gnt & ~wr & ~mis;
  end

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    assign rdata[i] = rd_q[i] ? mem_rdata : '0;
  end

  assign p0_gnt       = gnt[0];
  assign p1_gnt       = gnt[1];
  assign p0_rvalid    = rvalid_q[0];
  assign p1_rvalid    = rvalid_q[1];
  assign p0_err       = err_q[0];
  assign p1_err       = err_q[1];
  assign p0_rdata     = rdata[0];
  assign p1_rdata     = rdata[1];
  assign lock_timeout = tmo_q;

  a_gnt_onehot: assert property (@(posedge clk) $onehot0(gnt));

endmodule
